// File: rtl/prbs21_checker.sv
// -----------------------------------------------------------------------------
// prbs21_checker
//   Receive-side checker for a PRBS21 (x^21 + x^19 + 1) serial stream.
//   Seeds a 21-bit history from the incoming bits, verifies LOCK_LEN
//   consecutive predictions before declaring lock, then counts checked bits
//   and bit errors.  Lock is dropped when ERR_THRESH errors land inside one
//   ERR_WIN-bit window.
//
// Ports
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset
//   en_i       : data_i holds a valid received bit this cycle
//   data_i     : received serial bit
//   clr_i      : zero bit_cnt_o / err_cnt_o on the next edge
//   locked_o   : registered, 1 while aligned to the stream
//   err_o      : registered one-cycle pulse per bit error while locked
//   bit_cnt_o  : saturating count of valid bits checked while locked
//   err_cnt_o  : saturating count of bit errors seen while locked
// -----------------------------------------------------------------------------
module prbs21_checker #(
    parameter int unsigned LOCK_LEN   = 32'd64,
    parameter int unsigned ERR_WIN    = 32'd256,
    parameter int unsigned ERR_THRESH = 32'd16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        data_i,
    input  logic        clr_i,
    output logic        locked_o,
    output logic        err_o,
    output logic [63:0] bit_cnt_o,
    output logic [63:0] err_cnt_o
);

    // Counter widths; each counter only needs to reach its limit minus one
    // because the limit itself is detected on the incrementing cycle.
    localparam int unsigned MATCH_W = (LOCK_LEN   > 32'd1) ? $clog2(LOCK_LEN)   : 32'd1;
    localparam int unsigned WIN_W   = (ERR_WIN    > 32'd1) ? $clog2(ERR_WIN)    : 32'd1;
    localparam int unsigned ERR_W   = (ERR_THRESH > 32'd1) ? $clog2(ERR_THRESH) : 32'd1;

    localparam logic [MATCH_W-1:0] MATCH_LAST  = MATCH_W'(LOCK_LEN - 32'd1);
    localparam logic [MATCH_W-1:0] MATCH_ONE   = MATCH_W'(32'd1);
    localparam logic [MATCH_W-1:0] MATCH_ZERO  = {MATCH_W{1'b0}};
    localparam logic [WIN_W-1:0]   WIN_LAST    = WIN_W'(ERR_WIN - 32'd1);
    localparam logic [WIN_W-1:0]   WIN_ONE     = WIN_W'(32'd1);
    localparam logic [WIN_W-1:0]   WIN_ZERO    = {WIN_W{1'b0}};
    localparam logic [ERR_W-1:0]   THRESH_LAST = ERR_W'(ERR_THRESH - 32'd1);
    localparam logic [ERR_W-1:0]   ERR_ONE     = ERR_W'(32'd1);
    localparam logic [ERR_W-1:0]   ERR_ZERO    = {ERR_W{1'b0}};
    localparam logic [4:0]         SEED_FULL   = 5'd21;
    localparam logic [63:0]        CNT_MAX     = {64{1'b1}};

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // PRBS21 prediction: r[0] is the newest bit, taps at bits 21 and 19 back.
    function automatic logic prbs21_pred(input logic [20:0] hist);
        return hist[20] ^ hist[18];
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [20:0]        hist_r;
    logic [20:0]        hist_nxt_s;
    logic [4:0]         seed_cnt_r;
    logic [4:0]         seed_nxt_s;
    logic [MATCH_W-1:0] match_cnt_r;
    logic [MATCH_W-1:0] match_nxt_s;
    logic [WIN_W-1:0]   win_cnt_r;
    logic [WIN_W-1:0]   win_cnt_nxt_s;
    logic [ERR_W-1:0]   win_err_r;
    logic [ERR_W-1:0]   win_err_nxt_s;
    logic               pred_s;
    logic               mismatch_s;
    logic               bit_hit_s;
    logic               err_hit_s;

    // Next-state, history and window logic; nothing moves unless en_i is set.
    always_comb begin
        pred_s        = prbs21_pred(hist_r);
        mismatch_s    = data_i ^ pred_s;
        state_nxt_s   = state_r;
        hist_nxt_s    = hist_r;
        seed_nxt_s    = seed_cnt_r;
        match_nxt_s   = match_cnt_r;
        win_cnt_nxt_s = win_cnt_r;
        win_err_nxt_s = win_err_r;
        bit_hit_s     = 1'b0;
        err_hit_s     = 1'b0;
        if (en_i) begin
            case (state_r)
                ST_SEED: begin
                    hist_nxt_s = {hist_r[19:0], data_i};
                    if (seed_cnt_r != SEED_FULL) begin
                        seed_nxt_s = seed_cnt_r + 5'd1;
                    end else begin
                        seed_nxt_s = seed_cnt_r;
                    end
                    // An all-zero history is the LFSR lock-up state; keep
                    // shifting until real data has arrived.
                    if ((seed_nxt_s == SEED_FULL) && (hist_nxt_s != 21'd0)) begin
                        state_nxt_s = ST_VERIFY;
                        match_nxt_s = MATCH_ZERO;
                    end else begin
                        state_nxt_s = ST_SEED;
                    end
                end
                ST_VERIFY: begin
                    hist_nxt_s = {hist_r[19:0], data_i};
                    if (!mismatch_s) begin
                        if (match_cnt_r == MATCH_LAST) begin
                            state_nxt_s   = ST_LOCKED;
                            match_nxt_s   = MATCH_ZERO;
                            win_cnt_nxt_s = WIN_ZERO;
                            win_err_nxt_s = ERR_ZERO;
                        end else begin
                            match_nxt_s = match_cnt_r + MATCH_ONE;
                        end
                    end else begin
                        state_nxt_s = ST_SEED;
                        seed_nxt_s  = 5'd0;
                        match_nxt_s = MATCH_ZERO;
                    end
                end
                ST_LOCKED: begin
                    // Feed back the prediction so a received error cannot
                    // poison the following predictions.
                    hist_nxt_s = {hist_r[19:0], pred_s};
                    bit_hit_s  = 1'b1;
                    err_hit_s  = mismatch_s;
                    if (mismatch_s && (win_err_r == THRESH_LAST)) begin
                        // Threshold wins over a simultaneous window wrap.
                        state_nxt_s   = ST_SEED;
                        seed_nxt_s    = 5'd0;
                        match_nxt_s   = MATCH_ZERO;
                        win_cnt_nxt_s = WIN_ZERO;
                        win_err_nxt_s = ERR_ZERO;
                    end else if (win_cnt_r == WIN_LAST) begin
                        win_cnt_nxt_s = WIN_ZERO;
                        win_err_nxt_s = ERR_ZERO;
                    end else begin
                        win_cnt_nxt_s = win_cnt_r + WIN_ONE;
                        if (mismatch_s) begin
                            win_err_nxt_s = win_err_r + ERR_ONE;
                        end else begin
                            win_err_nxt_s = win_err_r;
                        end
                    end
                end
                default: begin
                    state_nxt_s   = ST_SEED;
                    hist_nxt_s    = 21'd0;
                    seed_nxt_s    = 5'd0;
                    match_nxt_s   = MATCH_ZERO;
                    win_cnt_nxt_s = WIN_ZERO;
                    win_err_nxt_s = ERR_ZERO;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM, history, window registers and the registered lock/error flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_SEED;
            hist_r      <= 21'd0;
            seed_cnt_r  <= 5'd0;
            match_cnt_r <= MATCH_ZERO;
            win_cnt_r   <= WIN_ZERO;
            win_err_r   <= ERR_ZERO;
            locked_o    <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            hist_r      <= hist_nxt_s;
            seed_cnt_r  <= seed_nxt_s;
            match_cnt_r <= match_nxt_s;
            win_cnt_r   <= win_cnt_nxt_s;
            win_err_r   <= win_err_nxt_s;
            locked_o    <= (state_nxt_s == ST_LOCKED);
            err_o       <= err_hit_s;
        end
    end

    // Saturating statistics counters; clr_i overrides a same-cycle increment.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bit_cnt_o <= 64'd0;
            err_cnt_o <= 64'd0;
        end else if (clr_i) begin
            bit_cnt_o <= 64'd0;
            err_cnt_o <= 64'd0;
        end else begin
            if (bit_hit_s && (bit_cnt_o != CNT_MAX)) begin
                bit_cnt_o <= bit_cnt_o + 64'd1;
            end else begin
                bit_cnt_o <= bit_cnt_o;
            end
            if (err_hit_s && (err_cnt_o != CNT_MAX)) begin
                err_cnt_o <= err_cnt_o + 64'd1;
            end else begin
                err_cnt_o <= err_cnt_o;
            end
        end
    end

endmodule

// File: tb/tb_prbs21_checker.sv
// -----------------------------------------------------------------------------
// tb_prbs21_checker
//   Directed and randomized stimulus for prbs21_checker.  A PRBS21 source
//   produces the transmitted stream; a behavioural model tracks the expected
//   lock mode, error pulse and statistics every clock.
// -----------------------------------------------------------------------------
module tb_prbs21_checker;

    localparam int LOCK_LEN   = 64;
    localparam int ERR_WIN    = 256;
    localparam int ERR_THRESH = 16;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic        data_i;
    logic        clr_i;
    logic        locked_o;
    logic        err_o;
    logic [63:0] bit_cnt_o;
    logic [63:0] err_cnt_o;

    prbs21_checker #(
        .LOCK_LEN   (LOCK_LEN),
        .ERR_WIN    (ERR_WIN),
        .ERR_THRESH (ERR_THRESH)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .en_i      (en_i),
        .data_i    (data_i),
        .clr_i     (clr_i),
        .locked_o  (locked_o),
        .err_o     (err_o),
        .bit_cnt_o (bit_cnt_o),
        .err_cnt_o (err_cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Transmitter state and reference model
    logic [20:0]     tx_state;
    int              m_mode;     // 0 seeding, 1 verifying, 2 locked
    bit              m_bits_q[$];
    int              m_seeded;
    int              m_matches;
    int              m_wpos;
    int              m_werr;
    longint unsigned m_bits;
    longint unsigned m_errs;
    logic            exp_locked;
    logic            exp_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // Predicted next bit from the last 21 received/predicted bits
    function automatic bit model_pred();
        int n;
        n = m_bits_q.size();
        return m_bits_q[n-21] ^ m_bits_q[n-19];
    endfunction

    function automatic bit model_hist_zero();
        int n;
        n = m_bits_q.size();
        for (int k = n - 21; k < n; k++) begin
            if (m_bits_q[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_push(input bit b);
        m_bits_q.push_back(b);
        if (m_bits_q.size() > 21) void'(m_bits_q.pop_front());
    endtask

    task automatic model_reset();
        m_bits_q.delete();
        for (int k = 0; k < 21; k++) m_bits_q.push_back(1'b0);
        m_mode = 0; m_seeded = 0; m_matches = 0; m_wpos = 0; m_werr = 0;
        m_bits = 0; m_errs = 0;
    endtask

    task automatic model_step(input logic en, input logic d, input logic clr, input logic rst);
        bit p;
        exp_err = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            if (en) begin
                p = model_pred();
                if (m_mode == 0) begin
                    model_push(d);
                    if (m_seeded < 21) m_seeded++;
                    if (m_seeded == 21 && !model_hist_zero()) begin
                        m_mode = 1; m_matches = 0;
                    end
                end else if (m_mode == 1) begin
                    model_push(d);
                    if (d == p) begin
                        m_matches++;
                        if (m_matches == LOCK_LEN) begin
                            m_mode = 2; m_wpos = 0; m_werr = 0;
                        end
                    end else begin
                        m_mode = 0; m_seeded = 0; m_matches = 0;
                    end
                end else begin
                    model_push(p);
                    m_bits++;
                    if (d != p) begin
                        m_errs++; m_werr++; exp_err = 1'b1;
                    end
                    if (m_werr >= ERR_THRESH) begin
                        m_mode = 0; m_seeded = 0; m_matches = 0; m_wpos = 0; m_werr = 0;
                    end else begin
                        m_wpos++;
                        if (m_wpos == ERR_WIN) begin
                            m_wpos = 0; m_werr = 0;
                        end
                    end
                end
            end
            if (clr) begin
                m_bits = 0; m_errs = 0;
            end
        end
        exp_locked = (m_mode == 2);
    endtask

    // One clock: drive, advance, then compare every output against the model
    task automatic cyc(input logic en, input logic d, input logic clr, input logic rst);
        en_i = en; data_i = d; clr_i = clr; rst_i = rst;
        @(posedge clk);
        #1;
        model_step(en, d, clr, rst);
        check("locked_o",  64'(locked_o), 64'(exp_locked));
        check("err_o",     64'(err_o),    64'(exp_err));
        check("bit_cnt_o", bit_cnt_o,     m_bits);
        check("err_cnt_o", err_cnt_o,     m_errs);
    endtask

    task automatic tx_bit(output logic b);
        b = tx_state[20] ^ tx_state[18];
        tx_state = {tx_state[19:0], b};
    endtask

    task automatic send(input logic flip);
        logic b;
        tx_bit(b);
        cyc(1'b1, b ^ flip, 1'b0, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 1'($urandom), 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic send_mixed(input int n);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(3) == 0) idle();
            else send(1'b0);
        end
    endtask

    initial begin
        longint unsigned saved_bits;
        logic            b;
        int              r;

        rst_i = 1'b1; en_i = 1'b0; data_i = 1'b0; clr_i = 1'b0;
        tx_state = 21'($urandom);
        if (tx_state == 21'd0) tx_state = 21'd1;
        model_reset();

        // Reset state
        do_reset();
        do_reset();
        check("rst_locked",  64'(locked_o), 64'd0);
        check("rst_bit_cnt", bit_cnt_o,     64'd0);

        // All-zero input never locks
        for (int k = 0; k < 1000; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("zero_no_lock", 64'(locked_o), 64'd0);

        // Clean stream: lock after valid bit 85
        do_reset();
        for (int k = 0; k < 84; k++) send(1'b0);
        check("prelock_84", 64'(locked_o), 64'd0);
        send(1'b0);
        check("lock_85",     64'(locked_o), 64'd1);
        check("lock_errcnt", err_cnt_o,     64'd0);

        // Single flipped bit while locked
        send_mixed(200);
        send(1'b1);
        check("single_err_pulse", 64'(err_o),  64'd1);
        check("single_err_cnt",   err_cnt_o,   64'd1);
        send_mixed(300);
        check("no_followon",  err_cnt_o,     64'd1);
        check("still_locked", 64'(locked_o), 64'd1);

        // Clear coinciding with a counted bit
        tx_bit(b);
        cyc(1'b1, b, 1'b1, 1'b0);
        check("clr_bit_cnt", bit_cnt_o, 64'd0);
        check("clr_err_cnt", err_cnt_o, 64'd0);

        // en_i low for 50 cycles holds everything
        for (int k = 0; k < 10; k++) send(1'b0);
        saved_bits = m_bits;
        for (int k = 0; k < 50; k++) idle();
        check("idle_bit_cnt", bit_cnt_o,     saved_bits);
        check("idle_locked",  64'(locked_o), 64'd1);
        for (int k = 0; k < 20; k++) send(1'b0);
        check("idle_no_err", err_cnt_o, 64'd0);

        // Threshold errors inside one window drop lock; re-lock retains count
        do_reset();
        for (int k = 0; k < 85; k++) send(1'b0);
        check("win_locked", 64'(locked_o), 64'd1);
        for (int k = 0; k < 15; k++) send(1'b1);
        check("pre_thresh", 64'(locked_o), 64'd1);
        send(1'b1);
        check("thresh_unlock",  64'(locked_o), 64'd0);
        check("thresh_err_cnt", err_cnt_o,     64'd16);
        for (int k = 0; k < 84; k++) send(1'b0);
        check("relock_84", 64'(locked_o), 64'd0);
        send(1'b0);
        check("relock_85",      64'(locked_o), 64'd1);
        check("retain_err_cnt", err_cnt_o,     64'd16);

        // Error at verify match 30 restarts seeding
        do_reset();
        for (int k = 0; k < 21 + 29; k++) send(1'b0);
        send(1'b1);
        for (int k = 0; k < 84; k++) send(1'b0);
        check("verify_err_84", 64'(locked_o), 64'd0);
        send(1'b0);
        check("verify_err_85", 64'(locked_o), 64'd1);

        // Reset in mid-lock
        do_reset();
        check("midlock_rst",     64'(locked_o), 64'd0);
        check("midlock_rst_cnt", bit_cnt_o,     64'd0);

        // Randomized soak against the model
        for (int k = 0; k < 4000; k++) begin
            r = int'($urandom_range(999));
            if (r < 2) begin
                do_reset();
            end else if (r < 8) begin
                if ($urandom_range(1) == 0) begin
                    tx_bit(b);
                    cyc(1'b1, b, 1'b1, 1'b0);
                end else begin
                    cyc(1'b0, 1'($urandom), 1'b1, 1'b0);
                end
            end else if (r < 10) begin
                for (int j = 0; j < 20; j++) send(1'b1);
            end else if (r < 250) begin
                idle();
            end else begin
                send(($urandom_range(99) < 2) ? 1'b1 : 1'b0);
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/prbs21_checker.md
PRBS21_CHECKER -- requirements
Module: prbs21_checker

Interface
REQ-001 SHALL have parameter LOCK_LEN, default 64: consecutive matching valid bits needed to declare lock.
REQ-002 SHALL have parameter ERR_WIN, default 256: length of the error-rate window, in valid bits.
REQ-003 SHALL have parameter ERR_THRESH, default 16: in-window error count that drops lock.
REQ-004 SHALL have port clk_i, input, 1 bit: single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port en_i, input, 1 bit: data_i carries a valid received bit this cycle.
REQ-007 SHALL have port data_i, input, 1 bit: received serial bit from the rx stage.
REQ-008 SHALL have port clr_i, input, 1 bit: clear the statistics counters.
REQ-009 SHALL have port locked_o, output, 1 bit: checker is aligned to the PRBS21 stream.
REQ-010 SHALL have port err_o, output, 1 bit: one-cycle pulse marking a bit error while locked.
REQ-011 SHALL have port bit_cnt_o, output, 64 bits: number of valid bits checked while locked.
REQ-012 SHALL have port err_cnt_o, output, 64 bits: number of bit errors counted while locked.

Function
REQ-013 SHALL hold a 21-bit history register r, where r[0] is the newest bit.
REQ-014 SHALL compute the predicted bit p = r[20] XOR r[18] (polynomial x^21+x^19+1).
REQ-015 SHALL hold an FSM with states SEED, VERIFY and LOCKED; the FSM and all counters advance only on cycles with en_i=1.
REQ-016 SEED: SHALL shift data_i into r and count seeded bits; after 21 seeded bits with r nonzero, next state is VERIFY; if r is all-zero, it stays in SEED and keeps shifting.
REQ-017 VERIFY: SHALL compare data_i with p and shift data_i into r. On a match, the consecutive-match counter increments; when it reaches LOCK_LEN, next state is LOCKED. On a mismatch, next state is SEED and the seed and match counters clear.
REQ-018 LOCKED: SHALL shift p (not data_i) into r, so that one received error never corrupts later predictions.
REQ-019 LOCKED: on each valid bit SHALL increment bit_cnt_o; on a mismatch it SHALL also increment err_cnt_o and the in-window error count, and pulse err_o.
REQ-020 LOCKED: the window counter SHALL count valid bits 0..ERR_WIN-1 and wrap to 0, clearing the in-window error count at the wrap.
REQ-021 When the in-window error count reaches ERR_THRESH, next state SHALL be SEED; this check takes priority over the window wrap in the same cycle.
REQ-022 locked_o SHALL be registered and equal 1 exactly when the state is LOCKED; it rises on the cycle after the LOCK_LEN-th match.
REQ-023 err_o SHALL assert for one cycle, on the cycle after the errored en_i sample; it is 0 on every other cycle.
REQ-024 bit_cnt_o and err_cnt_o SHALL saturate at 2^64-1; they hold their values across lock loss and re-lock.
REQ-025 clr_i SHALL zero both counters on the next edge without affecting the FSM, r or the window logic; clr_i with a simultaneous counted bit yields 0, not 1.
REQ-026 SHALL drive every output from a register; there are no combinational input-to-output paths.

Reset
REQ-027 When rst_i=1 at a clock edge, the block SHALL set: state SEED, r=0, all internal counters=0, locked_o=0, err_o=0, bit_cnt_o=0, err_cnt_o=0.
REQ-028 rst_i SHALL take priority over en_i and clr_i; reset in mid-lock returns to SEED on the next edge.

Verification
REQ-029 Reset, then clean PRBS21 with en_i=1 every cycle -> locked_o rises after valid bit 85 (21+64), and err_o stays 0.
REQ-030 Locked, flip one bit -> one err_o pulse, err_cnt_o=1, locked_o stays 1, and no follow-on errors.
REQ-031 Locked, flip 16 bits within one 256-bit window -> locked_o=0 on the cycle after the 16th error; clean data re-locks after 85 further bits; err_cnt_o=16 is retained.
REQ-032 Error at VERIFY match 30 -> return to SEED; locked_o rises only after 21+64 further clean bits.
REQ-033 All-zero input for 1000 bits -> locked_o stays 0.
REQ-034 clr_i pulsed together with a locked valid bit -> bit_cnt_o=0 next cycle; en_i held low for 50 cycles mid-lock -> all state and outputs unchanged.
